// File: rtl/pot_spi_master_if.sv
// Potentiometer SPI engine bundle: requester handshake, command/readback words and serial pins.
// master = engine side, slave = requester/potentiometer side.
interface pot_spi_master_if;
    logic        send_data_spi;
    logic [15:0] dat_spi_out;
    logic        pot_sdo;
    logic        pot_sclk;
    logic        pot_sync_;
    logic        pot_din;
    logic        pot_busy;
    logic        send_ok_strobe;
    logic [15:0] pot_rd_data;

    modport master (
        input  send_data_spi, dat_spi_out, pot_sdo,
        output pot_sclk, pot_sync_, pot_din, pot_busy, send_ok_strobe, pot_rd_data
    );

    modport slave (
        output send_data_spi, dat_spi_out, pot_sdo,
        input  pot_sclk, pot_sync_, pot_din, pot_busy, send_ok_strobe, pot_rd_data
    );
endinterface

// File: rtl/pot_spi_master.sv
// 16-bit mode-1 SPI master for a digital potentiometer; one frame per request rising edge.
// Latency: T_CSS+32*CLK_DIV+T_CSH+T_GAP busy cycles; requests outside IDLE are ignored.
module pot_spi_master #(
    parameter int CLK_DIV = 4,
    parameter int T_CSS   = 2,
    parameter int T_CSH   = 2,
    parameter int T_GAP   = 4
) (
    input  logic             clk,
    input  logic             rst,
    pot_spi_master_if.master bus
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t      state, state_nxt;
    logic        req_d;
    logic [31:0] tmr, tmr_nxt;
    logic [4:0]  bit_cnt, bit_cnt_nxt;
    logic [15:0] tx, tx_nxt;
    logic [15:0] rx, rx_nxt;
    logic        sclk_q, sclk_nxt;
    logic        sync_q, sync_nxt;
    logic        din_q, din_nxt;
    logic        busy_q, busy_nxt;
    logic        strobe_q, strobe_nxt;
    logic [15:0] rd_q, rd_nxt;

    logic start;
    logic tmr_done;
    logic last_bit;

    assign start    = (state == IDLE) && bus.send_data_spi && !req_d;
    assign last_bit = (bit_cnt == 5'd16);

    always_comb begin
        tmr_done = 1'b0;
        case (state)
            SETUP:   tmr_done = (tmr == 32'(T_CSS - 1));
            SHIFT:   tmr_done = (tmr == 32'(CLK_DIV - 1));
            HOLD:    tmr_done = (tmr == 32'(T_CSH - 1));
            GAP:     tmr_done = (tmr == 32'(T_GAP - 1));
            default: tmr_done = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = SETUP;
            SETUP:   if (tmr_done) state_nxt = SHIFT;
            // The trailing low half of bit 16 belongs to SHIFT so a frame spans 32*CLK_DIV cycles.
            SHIFT:   if (tmr_done && !sclk_q && last_bit) state_nxt = HOLD;
            HOLD:    if (tmr_done) state_nxt = GAP;
            GAP:     if (tmr_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tmr_nxt     = (state == IDLE || tmr_done) ? 32'd0 : tmr + 32'd1;
        bit_cnt_nxt = bit_cnt;
        tx_nxt      = tx;
        rx_nxt      = rx;
        sclk_nxt    = sclk_q;
        sync_nxt    = sync_q;
        din_nxt     = din_q;
        busy_nxt    = busy_q;
        strobe_nxt  = 1'b0;
        rd_nxt      = rd_q;
        case (state)
            IDLE: begin
                if (start) begin
                    tx_nxt      = bus.dat_spi_out;
                    rx_nxt      = 16'h0000;
                    bit_cnt_nxt = 5'd0;
                    sync_nxt    = 1'b0;
                    busy_nxt    = 1'b1;
                end
            end
            SETUP: begin
                if (tmr_done) begin
                    sclk_nxt = 1'b1;
                    din_nxt  = tx[15];
                end
            end
            SHIFT: begin
                if (tmr_done) begin
                    if (sclk_q) begin
                        sclk_nxt    = 1'b0;
                        rx_nxt      = {rx[14:0], bus.pot_sdo};
                        tx_nxt      = {tx[14:0], 1'b0};
                        bit_cnt_nxt = bit_cnt + 5'd1;
                    end else if (!last_bit) begin
                        sclk_nxt = 1'b1;
                        din_nxt  = tx[15];
                    end
                end
            end
            HOLD: begin
                if (tmr_done) begin
                    sync_nxt   = 1'b1;
                    strobe_nxt = 1'b1;
                    rd_nxt     = rx;
                end
            end
            GAP: begin
                if (tmr_done) busy_nxt = 1'b0;
            end
            default: ;
        endcase
    end

    // req_d resets high so a request already asserted at reset release is not an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_d    <= 1'b1;
            tmr      <= 32'd0;
            bit_cnt  <= 5'd0;
            tx       <= 16'h0000;
            rx       <= 16'h0000;
            sclk_q   <= 1'b0;
            sync_q   <= 1'b1;
            din_q    <= 1'b0;
            busy_q   <= 1'b0;
            strobe_q <= 1'b0;
            rd_q     <= 16'h0000;
        end else begin
            req_d    <= bus.send_data_spi;
            tmr      <= tmr_nxt;
            bit_cnt  <= bit_cnt_nxt;
            tx       <= tx_nxt;
            rx       <= rx_nxt;
            sclk_q   <= sclk_nxt;
            sync_q   <= sync_nxt;
            din_q    <= din_nxt;
            busy_q   <= busy_nxt;
            strobe_q <= strobe_nxt;
            rd_q     <= rd_nxt;
        end
    end

    assign bus.pot_sclk       = sclk_q;
    assign bus.pot_sync_      = sync_q;
    assign bus.pot_din        = din_q;
    assign bus.pot_busy       = busy_q;
    assign bus.send_ok_strobe = strobe_q;
    assign bus.pot_rd_data    = rd_q;

endmodule

// File: tb/tb_pot_spi_master.sv
// Directed bench for pot_spi_master: default-timing instance with a slave model, plus a CLK_DIV=1 instance.
module tb_pot_spi_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pot_spi_master_if ia ();
    pot_spi_master_if ib ();

    logic        send_a = 1'b0;
    logic        send_b = 1'b0;
    logic [15:0] dat_a  = 16'h0000;
    logic [15:0] dat_b  = 16'h0000;
    logic        sdo_a  = 1'b0;
    logic [15:0] slave_word = 16'hA5C3;
    int          sidx = 0;

    assign ia.send_data_spi = send_a;
    assign ia.dat_spi_out   = dat_a;
    assign ia.pot_sdo       = sdo_a;
    assign ib.send_data_spi = send_b;
    assign ib.dat_spi_out   = dat_b;
    assign ib.pot_sdo       = 1'b0;

    pot_spi_master u_dut_a (.clk(clk), .rst(rst), .bus(ia.master));

    pot_spi_master #(.CLK_DIV(1), .T_CSS(1), .T_CSH(1), .T_GAP(1))
        u_dut_b (.clk(clk), .rst(rst), .bus(ib.master));

    // Slave presents the next readback bit on each SCLK rise; chip-select high rewinds it.
    always @(posedge ia.pot_sclk or posedge ia.pot_sync_) begin
        if (ia.pot_sync_) begin
            sidx = 0;
        end else begin
            sdo_a = slave_word[15 - sidx];
            sidx  = sidx + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    int          m_busy, m_pulses, m_strobes, m_css, m_bad, m_gap;
    logic [15:0] m_din, m_rd;
    logic        m_sync_at_strobe;
    bit          m_done;

    task automatic watch(input bit sel, input int div, input bit pulse,
                         input int glitch_at, input logic [15:0] dat_after);
        bit   seen = 1'b0;
        logic prev = 1'b0;
        int   hi_run = 0;
        int   lo_run = 0;
        logic s_sclk, s_sync, s_din, s_busy, s_strobe;
        logic [15:0] s_rd;
        m_busy = 0; m_pulses = 0; m_strobes = 0; m_css = 0; m_bad = 0; m_gap = 0;
        m_din = 16'h0000; m_rd = 16'h0000; m_sync_at_strobe = 1'b0; m_done = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            s_sclk   = sel ? ib.pot_sclk       : ia.pot_sclk;
            s_sync   = sel ? ib.pot_sync_      : ia.pot_sync_;
            s_din    = sel ? ib.pot_din        : ia.pot_din;
            s_busy   = sel ? ib.pot_busy       : ia.pot_busy;
            s_strobe = sel ? ib.send_ok_strobe : ia.send_ok_strobe;
            s_rd     = sel ? ib.pot_rd_data    : ia.pot_rd_data;
            if (s_busy) begin m_busy++; seen = 1'b1; end
            if (s_strobe) begin m_strobes++; m_rd = s_rd; m_sync_at_strobe = s_sync; end
            if (m_strobes > 0 && s_busy) m_gap++;
            if (s_sclk && !prev) begin
                m_pulses++;
                if (m_pulses > 1 && lo_run != div) m_bad++;
                hi_run = 0;
            end
            if (!s_sclk && prev) begin
                m_din = {m_din[14:0], s_din};
                if (hi_run != div) m_bad++;
                lo_run = 0;
            end
            if (s_sclk) hi_run++; else lo_run++;
            if (!s_sync && m_pulses == 0 && !s_sclk) m_css++;
            prev = s_sclk;
            if (i == 0) begin
                if (sel) begin dat_b = dat_after; if (pulse) send_b = 1'b0; end
                else     begin dat_a = dat_after; if (pulse) send_a = 1'b0; end
            end
            if (glitch_at >= 0 && i == glitch_at)     send_a = 1'b0;
            if (glitch_at >= 0 && i == glitch_at + 1) send_a = 1'b1;
            if (seen && !s_busy) begin m_done = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (ia.pot_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", ia.pot_sclk); end
        checks++; if (ia.pot_sync_ !== 1'b1) begin errors++; $display("FAIL reset_sync got %b want 1", ia.pot_sync_); end
        checks++; if (ia.pot_din !== 1'b0) begin errors++; $display("FAIL reset_din got %b want 0", ia.pot_din); end
        checks++; if (ia.pot_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", ia.pot_busy); end
        checks++; if (ia.send_ok_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b want 0", ia.send_ok_strobe); end
        checks++; if (ia.pot_rd_data !== 16'h0000) begin errors++; $display("FAIL reset_rd got %h want 0000", ia.pot_rd_data); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_frame;
        dat_a  = 16'h1802;
        send_a = 1'b1;
        watch(1'b0, 4, 1'b1, -1, 16'hFFFF);
        checks++; if (m_done !== 1'b1) begin errors++; $display("FAIL frame_timeout got %b want 1", m_done); end
        checks++; if (m_busy != 136) begin errors++; $display("FAIL frame_busy got %0d want 136", m_busy); end
        checks++; if (m_pulses != 16) begin errors++; $display("FAIL frame_pulses got %0d want 16", m_pulses); end
        checks++; if (m_bad != 0) begin errors++; $display("FAIL frame_phase_len got %0d bad want 0", m_bad); end
        checks++; if (m_css != 2) begin errors++; $display("FAIL frame_css got %0d want 2", m_css); end
        checks++; if (m_din !== 16'h1802) begin errors++; $display("FAIL frame_din got %h want 1802", m_din); end
        checks++; if (m_strobes != 1) begin errors++; $display("FAIL frame_strobes got %0d want 1", m_strobes); end
        checks++; if (m_rd !== 16'hA5C3) begin errors++; $display("FAIL frame_rd got %h want a5c3", m_rd); end
        checks++; if (m_sync_at_strobe !== 1'b1) begin errors++; $display("FAIL frame_sync_at_strobe got %b want 1", m_sync_at_strobe); end
        checks++; if (m_gap != 4) begin errors++; $display("FAIL frame_gap got %0d want 4", m_gap); end
    endtask

    task automatic test_back_to_back;
        int extra_busy = 0;
        repeat (3) @(negedge clk);
        dat_a  = 16'h3C5A;
        send_a = 1'b1;
        watch(1'b0, 4, 1'b0, 40, 16'h3C5A);
        checks++; if (m_strobes != 1) begin errors++; $display("FAIL b2b_first_strobes got %0d want 1", m_strobes); end
        checks++; if (m_pulses != 16) begin errors++; $display("FAIL b2b_first_pulses got %0d want 16", m_pulses); end
        checks++; if (m_din !== 16'h3C5A) begin errors++; $display("FAIL b2b_first_din got %h want 3c5a", m_din); end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ia.pot_busy) extra_busy++;
        end
        checks++; if (extra_busy != 0) begin errors++; $display("FAIL b2b_level_retrigger got %0d busy cycles want 0", extra_busy); end
        slave_word = 16'h0F0F;
        dat_a  = 16'h8001;
        send_a = 1'b0;
        @(negedge clk);
        send_a = 1'b1;
        watch(1'b0, 4, 1'b1, -1, 16'h8001);
        checks++; if (m_strobes != 1) begin errors++; $display("FAIL b2b_second_strobes got %0d want 1", m_strobes); end
        checks++; if (m_din !== 16'h8001) begin errors++; $display("FAIL b2b_second_din got %h want 8001", m_din); end
        checks++; if (m_rd !== 16'h0F0F) begin errors++; $display("FAIL b2b_second_rd got %h want 0f0f", m_rd); end
    endtask

    task automatic test_reset_mid;
        int   falls = 0;
        logic prev = 1'b0;
        int   late = 0;
        repeat (3) @(negedge clk);
        dat_a  = 16'h1802;
        send_a = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            send_a = 1'b0;
            if (!ia.pot_sclk && prev) falls++;
            prev = ia.pot_sclk;
            if (falls == 7) begin rst = 1'b1; break; end
        end
        checks++; if (falls != 7) begin errors++; $display("FAIL mid_reach_fall7 got %0d want 7", falls); end
        @(negedge clk);
        checks++; if (ia.pot_sync_ !== 1'b1) begin errors++; $display("FAIL mid_sync got %b want 1", ia.pot_sync_); end
        checks++; if (ia.pot_sclk !== 1'b0) begin errors++; $display("FAIL mid_sclk got %b want 0", ia.pot_sclk); end
        checks++; if (ia.pot_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b want 0", ia.pot_busy); end
        checks++; if (ia.pot_rd_data !== 16'h0000) begin errors++; $display("FAIL mid_rd got %h want 0000", ia.pot_rd_data); end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ia.send_ok_strobe || ia.pot_sclk || ia.pot_busy) late++;
        end
        checks++; if (late != 0) begin errors++; $display("FAIL mid_after_activity got %0d want 0", late); end
    endtask

    task automatic test_fast;
        dat_b  = 16'hFFFF;
        send_b = 1'b1;
        watch(1'b1, 1, 1'b1, -1, 16'h0000);
        checks++; if (m_done !== 1'b1) begin errors++; $display("FAIL fast_timeout got %b want 1", m_done); end
        checks++; if (m_busy != 35) begin errors++; $display("FAIL fast_busy got %0d want 35", m_busy); end
        checks++; if (m_pulses != 16) begin errors++; $display("FAIL fast_pulses got %0d want 16", m_pulses); end
        checks++; if (m_bad != 0) begin errors++; $display("FAIL fast_phase_len got %0d bad want 0", m_bad); end
        checks++; if (m_din !== 16'hFFFF) begin errors++; $display("FAIL fast_din got %h want ffff", m_din); end
        checks++; if (m_css != 1) begin errors++; $display("FAIL fast_css got %0d want 1", m_css); end
        checks++; if (m_gap != 1) begin errors++; $display("FAIL fast_gap got %0d want 1", m_gap); end
        checks++; if (m_strobes != 1) begin errors++; $display("FAIL fast_strobes got %0d want 1", m_strobes); end
    endtask

    task automatic test_req_at_reset;
        int busy_seen = 0;
        rst    = 1'b1;
        send_a = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ia.pot_busy) busy_seen++;
        end
        checks++; if (busy_seen != 0) begin errors++; $display("FAIL rel_no_start got %0d busy cycles want 0", busy_seen); end
        send_a = 1'b0;
        @(negedge clk);
        send_a = 1'b1;
        watch(1'b0, 4, 1'b1, -1, 16'h0000);
        checks++; if (m_busy != 136) begin errors++; $display("FAIL rel_frame_busy got %0d want 136", m_busy); end
        checks++; if (m_strobes != 1) begin errors++; $display("FAIL rel_frame_strobes got %0d want 1", m_strobes); end
    endtask

    initial begin
        test_reset;
        test_frame;
        test_back_to_back;
        test_reset_mid;
        test_fast;
        test_req_at_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
